// File: rtl/npu_mmap_master_pkg.sv
// Memory map for the NPU slave window plus the shared types of the host-side bus master.
package npu_mmap_master_pkg;

  localparam logic [31:0] IMEM_START   = 32'h1000_0000;
  localparam logic [31:0] IMEM_END     = 32'h1000_1000;
  localparam logic [31:0] WMEM_START   = 32'h1001_0000;
  localparam logic [31:0] WMEM_END     = 32'h1001_4000;
  localparam logic [31:0] BMEM_START   = 32'h1002_0000;
  localparam logic [31:0] BMEM_END     = 32'h1002_0400;
  localparam logic [31:0] OMEM_START   = 32'h1003_0000;
  localparam logic [31:0] OMEM_END     = 32'h1003_2000;
  localparam logic [31:0] PARA_START   = 32'h1004_0000;
  localparam logic [31:0] PARA_END     = 32'h1004_0040;
  localparam logic [31:0] NPU_OP_START = 32'h1005_0000;

  typedef enum logic [2:0] {
    RGN_IMEM = 3'd0,
    RGN_WMEM = 3'd1,
    RGN_BMEM = 3'd2,
    RGN_OMEM = 3'd3,
    RGN_PARA = 3'd4
  } npu_region_e;

  typedef enum logic [1:0] {
    KICK_NONE    = 2'd0,
    KICK_OP0     = 2'd1,
    KICK_OP1     = 2'd2,
    KICK_ILLEGAL = 2'd3
  } npu_kick_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_KICK,
    ST_DONE
  } npu_mst_state_e;

  // Illegal region codes map to an empty window so any length is rejected.
  function automatic logic [31:0] region_start(input logic [2:0] region);
    case (region)
      RGN_IMEM: region_start = IMEM_START;
      RGN_WMEM: region_start = WMEM_START;
      RGN_BMEM: region_start = BMEM_START;
      RGN_OMEM: region_start = OMEM_START;
      RGN_PARA: region_start = PARA_START;
      default:  region_start = '0;
    endcase
  endfunction

  function automatic logic [31:0] region_end(input logic [2:0] region);
    case (region)
      RGN_IMEM: region_end = IMEM_END;
      RGN_WMEM: region_end = WMEM_END;
      RGN_BMEM: region_end = BMEM_END;
      RGN_OMEM: region_end = OMEM_END;
      RGN_PARA: region_end = PARA_END;
      default:  region_end = '0;
    endcase
  endfunction

endpackage

// File: rtl/npu_mmap_master_rd_skid.sv
// Two-entry read-data FIFO between the bus capture point and the read stream.
module npu_rd_skid #(
  parameter int DWidth = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DWidth-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DWidth-1:0] pop_data,
  output logic [1:0]        count
);

  logic [DWidth-1:0] mem [2];
  logic              rptr;
  logic              wptr;
  logic [1:0]        cnt;
  logic              pop;

  assign pop       = pop_valid && pop_ready;
  assign pop_valid = (cnt != 2'd0);
  assign pop_data  = mem[rptr];
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= 1'b0;
      wptr <= 1'b0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/npu_mmap_master.sv
// Host-side initiator: checks region-relative commands, streams bytes to/from the NPU slave, optional op kick.
module npu_mmap_master
  import npu_mmap_master_pkg::*;
#(
  parameter int DWidth     = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_dir_i,
  input  logic [2:0]            cmd_region_i,
  input  logic [ADDR_WIDTH-1:0] cmd_offset_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [1:0]            cmd_kick_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DWidth-1:0]     wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DWidth-1:0]     rd_data_o,
  output logic                  cen_o,
  output logic                  wen_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DWidth-1:0]     wdata_o,
  input  logic [DWidth-1:0]     rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int SumW = ADDR_WIDTH + 1;

  npu_mst_state_e        state_q, state_d;
  logic                  live_q;
  logic                  dir_q;
  logic [2:0]            region_q;
  logic [1:0]            kick_q;
  logic [ADDR_WIDTH-1:0] offset_q, start_q;
  logic [LEN_WIDTH-1:0]  len_q, idx_q;
  logic                  err_q;
  logic                  rd_beat_q, rd_push_q;
  logic                  cen_q, wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DWidth-1:0]     wdata_q;
  logic [1:0]            buf_count;
  logic [SumW-1:0]       span, size;
  logic                  illegal, last_idx, rd_issue;

  // Reads in flight are the beat on the bus (rd_beat_q) and the beat whose data is due now (rd_push_q).
  always_comb begin
    size     = SumW'(ADDR_WIDTH'(region_end(region_q) - region_start(region_q)));
    span     = SumW'(offset_q) + SumW'(len_q);
    illegal  = (region_q > 3'd4) || (kick_q == KICK_ILLEGAL) || (span > size);
    last_idx = (idx_q == len_q - LEN_WIDTH'(1));
    rd_issue = (state_q == ST_READ) &&
               (({1'b0, buf_count} + 3'(rd_beat_q) + 3'(rd_push_q)) < 3'd2);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid_i && live_q) state_d = ST_CHECK;
      ST_CHECK: begin
        if (illegal)                state_d = ST_DONE;
        else if (len_q == '0)       state_d = ST_KICK;
        else if (dir_q)             state_d = ST_READ;
        else                        state_d = ST_WRITE;
      end
      ST_WRITE: if (wr_valid_i && last_idx) state_d = ST_KICK;
      ST_READ:  if (rd_issue && last_idx)   state_d = ST_DRAIN;
      ST_DRAIN: if (!rd_beat_q && !rd_push_q && buf_count == 2'd0) state_d = ST_KICK;
      ST_KICK:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q    <= 1'b0;
      dir_q     <= 1'b0;
      region_q  <= '0;
      kick_q    <= '0;
      offset_q  <= '0;
      len_q     <= '0;
      start_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      rd_beat_q <= 1'b0;
      rd_push_q <= 1'b0;
      cen_q     <= 1'b1;
      wen_q     <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      live_q    <= 1'b1;
      cen_q     <= 1'b1;
      wen_q     <= 1'b1;
      rd_beat_q <= 1'b0;
      rd_push_q <= rd_beat_q;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i && live_q) begin
            dir_q    <= cmd_dir_i;
            region_q <= cmd_region_i;
            kick_q   <= cmd_kick_i;
            offset_q <= cmd_offset_i;
            len_q    <= cmd_len_i;
            idx_q    <= '0;
          end
        end
        ST_CHECK: begin
          start_q <= ADDR_WIDTH'(region_start(region_q)) + offset_q;
          err_q   <= illegal;
        end
        ST_WRITE: begin
          if (wr_valid_i) begin
            cen_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= start_q + ADDR_WIDTH'(idx_q);
            wdata_q <= wr_data_i;
            idx_q   <= idx_q + LEN_WIDTH'(1);
          end
        end
        ST_READ: begin
          if (rd_issue) begin
            cen_q     <= 1'b0;
            addr_q    <= start_q + ADDR_WIDTH'(idx_q);
            idx_q     <= idx_q + LEN_WIDTH'(1);
            rd_beat_q <= 1'b1;
          end
        end
        ST_KICK: begin
          if (kick_q != KICK_NONE) begin
            cen_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= (kick_q == KICK_OP1) ? ADDR_WIDTH'(NPU_OP_START + 32'd4)
                                            : ADDR_WIDTH'(NPU_OP_START);
            wdata_q <= DWidth'(1);
          end
        end
        default: ;
      endcase
    end
  end

  npu_rd_skid #(.DWidth(DWidth)) u_rd_skid (
    .clk       (clk),
    .rst_n     (rst_ni),
    .push      (rd_push_q),
    .push_data (rdata_i),
    .pop_valid (rd_valid_o),
    .pop_ready (rd_ready_i),
    .pop_data  (rd_data_o),
    .count     (buf_count)
  );

  assign cmd_ready_o = (state_q == ST_IDLE) && live_q;
  assign wr_ready_o  = (state_q == ST_WRITE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_DONE) && err_q;
  assign cen_o       = cen_q;
  assign wen_o       = wen_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_npu_mmap_master.sv
// Randomised and directed bench for npu_mmap_master against a transaction-level expectation model.
module tb_npu_mmap_master;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_dir_i = 1'b0;
  logic [2:0]  cmd_region_i = '0;
  logic [31:0] cmd_offset_i = '0;
  logic [15:0] cmd_len_i = '0;
  logic [1:0]  cmd_kick_i = '0;
  logic        wr_valid_i = 1'b0, wr_ready_o;
  logic [7:0]  wr_data_i = '0;
  logic        rd_valid_o, rd_ready_i;
  logic [7:0]  rd_data_o;
  logic        cen_o, wen_o;
  logic [31:0] addr_o;
  logic [7:0]  wdata_o, rdata_i;
  logic        busy_o, done_o, err_o;

  npu_mmap_master #(.DWidth(8), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_dir_i(cmd_dir_i),
    .cmd_region_i(cmd_region_i), .cmd_offset_i(cmd_offset_i), .cmd_len_i(cmd_len_i),
    .cmd_kick_i(cmd_kick_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .cen_o(cen_o), .wen_o(wen_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic wen; logic [31:0] addr; logic [7:0] data; } beat_t;
  typedef struct packed { logic err; logic gap_chk; logic [1:0] gap; } cmdx_t;

  beat_t      exp_beats[$];
  logic [7:0] exp_rd[$];
  cmdx_t      exp_cmd[$];
  logic [7:0] wbuf[0:15];

  int checks = 0, failures = 0;
  int cyc = 0, cmd_beats = 0, last_beat_cyc = 0, done_cnt = 0;
  int reads_issued = 0, reads_popped = 0;
  int beat_cyc[$];
  logic [7:0]  rd_log[$];
  logic [31:0] first_addr, last_addr;
  logic [7:0]  first_data, last_data;
  logic        last_err;
  logic        rd_toggle = 1'b0;
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0]  prev_d;
  beat_t       mb;
  cmdx_t       mc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h expected nothing", name, act);
  endtask

  // Memory map as the bench knows it: window base and window size per region code.
  function automatic logic [31:0] rstart(input logic [2:0] r);
    case (r)
      3'd0: rstart = 32'h1000_0000;
      3'd1: rstart = 32'h1001_0000;
      3'd2: rstart = 32'h1002_0000;
      3'd3: rstart = 32'h1003_0000;
      3'd4: rstart = 32'h1004_0000;
      default: rstart = 32'h0;
    endcase
  endfunction

  function automatic longint unsigned rsize(input logic [2:0] r);
    case (r)
      3'd0: rsize = 64'h1000;
      3'd1: rsize = 64'h4000;
      3'd2: rsize = 64'h400;
      3'd3: rsize = 64'h2000;
      3'd4: rsize = 64'h40;
      default: rsize = 64'h0;
    endcase
  endfunction

  // Slave read port: data for a read beat appears in the following cycle, junk otherwise.
  initial begin
    logic rb;
    logic [7:0] ra;
    rdata_i = '0;
    forever begin
      @(negedge clk);
      rb = !cen_o && wen_o && rst_ni;
      ra = addr_o[7:0];
      @(posedge clk);
      #1 rdata_i = rb ? ra : 8'($urandom);
    end
  end

  initial begin
    rd_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1 rd_ready_i = rd_toggle ? !rd_ready_i : ($urandom % 3 != 0);
    end
  end

  // Compare process: every cycle out of reset, bus beats, read stream and completion against the model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_ni) begin
        prev_v = 1'b0;
        continue;
      end
      if (!cen_o) begin
        cmd_beats++;
        beat_cyc.push_back(cyc);
        last_beat_cyc = cyc;
        if (cmd_beats == 1) begin first_addr = addr_o; first_data = wdata_o; end
        last_addr = addr_o;
        last_data = wdata_o;
        if (exp_beats.size() == 0) flag("unexpected_beat_addr", addr_o);
        else begin
          mb = exp_beats.pop_front();
          check("beat_wen", wen_o, mb.wen);
          check("beat_addr", addr_o, mb.addr);
          if (!mb.wen) check("beat_wdata", wdata_o, mb.data);
        end
        if (wen_o) begin
          reads_issued++;
          check("outstanding_le2", 64'(reads_issued - reads_popped), 64'(reads_issued - reads_popped > 2 ? 2 : reads_issued - reads_popped));
        end
      end
      if (prev_v && !prev_r) begin
        check("rd_hold_valid", rd_valid_o, 1'b1);
        check("rd_hold_data", rd_data_o, prev_d);
      end
      if (rd_valid_o && rd_ready_i) begin
        reads_popped++;
        rd_log.push_back(rd_data_o);
        if (exp_rd.size() == 0) flag("unexpected_rd_data", rd_data_o);
        else check("rd_data", rd_data_o, exp_rd.pop_front());
      end
      prev_v = rd_valid_o;
      prev_r = rd_ready_i;
      prev_d = rd_data_o;
      check("ready_while_busy", cmd_ready_o && busy_o, 1'b0);
      if (err_o && !done_o) flag("err_without_done", err_o);
      if (done_o) begin
        done_cnt++;
        last_err = err_o;
        if (exp_cmd.size() == 0) flag("unexpected_done", done_o);
        else begin
          mc = exp_cmd.pop_front();
          check("done_err", err_o, mc.err);
          if (mc.gap_chk) check("done_latency", 64'(cyc - last_beat_cyc), 64'(mc.gap));
          check("beats_left_at_done", 64'(exp_beats.size()), 0);
          check("reads_left_at_done", 64'(exp_rd.size()), 0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cen"}, cen_o, 1'b1);
    check({tag, "_wen"}, wen_o, 1'b1);
    check({tag, "_addr"}, addr_o, 32'h0);
    check({tag, "_wdata"}, wdata_o, 8'h0);
    check({tag, "_cmd_ready"}, cmd_ready_o, 1'b0);
    check({tag, "_wr_ready"}, wr_ready_o, 1'b0);
    check({tag, "_rd_valid"}, rd_valid_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  task automatic run_cmd(input logic dir, input logic [2:0] rg, input logic [31:0] off,
                         input int unsigned len, input logic [1:0] kick,
                         input int gap_pct, input int gap_at, input int abort_at);
    longint unsigned sum;
    logic legal, gapped;
    logic [31:0] a;
    int sent, budget, d0;
    beat_t b;
    cmdx_t c;
    sum   = longint'(off) + longint'(len);
    legal = (rg <= 3'd4) && (kick != 2'd3) && (sum <= rsize(rg));
    if (legal) begin
      for (int unsigned i = 0; i < len; i++) begin
        a = rstart(rg) + off + i;
        if (dir) begin
          b = '{1'b1, a, 8'h00};
          exp_rd.push_back(a[7:0]);
        end else b = '{1'b0, a, wbuf[i]};
        exp_beats.push_back(b);
      end
      if (kick == 2'd1) exp_beats.push_back('{1'b0, 32'h1005_0000, 8'h01});
      if (kick == 2'd2) exp_beats.push_back('{1'b0, 32'h1005_0004, 8'h01});
    end
    c.err     = !legal;
    c.gap_chk = legal && (kick != 2'd0 || (!dir && len != 0));
    c.gap     = (kick != 2'd0) ? 2'd0 : 2'd1;
    exp_cmd.push_back(c);
    cmd_beats = 0;
    beat_cyc.delete();
    rd_log.delete();
    reads_issued = 0;
    reads_popped = 0;

    budget = 0;
    @(negedge clk);
    while (!cmd_ready_o && budget < 200) begin @(negedge clk); budget++; end
    if (!cmd_ready_o) flag("cmd_ready_timeout", budget);
    cmd_valid_i = 1'b1; cmd_dir_i = dir; cmd_region_i = rg;
    cmd_offset_i = off; cmd_len_i = 16'(len); cmd_kick_i = kick;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    d0 = done_cnt; sent = 0; budget = 0; gapped = 1'b0;
    while (budget < 3000) begin
      cmd_valid_i = busy_o ? 1'($urandom % 2) : 1'b0;
      cmd_dir_i = 1'($urandom); cmd_region_i = 3'($urandom); cmd_offset_i = $urandom;
      cmd_len_i = 16'($urandom % 8); cmd_kick_i = 2'($urandom);
      if (!dir && legal && sent < int'(len)) begin
        if (sent == gap_at && !gapped) begin wr_valid_i = 1'b0; gapped = 1'b1; end
        else wr_valid_i = ($urandom % 100 >= gap_pct);
        wr_data_i = wr_valid_i ? wbuf[sent] : 8'($urandom);
      end else begin
        wr_valid_i = 1'($urandom);
        wr_data_i  = 8'($urandom);
      end
      @(negedge clk);
      if (wr_valid_i && wr_ready_o && sent < int'(len)) sent++;
      #2;
      if (abort_at > 0 && cmd_beats >= abort_at) begin
        rst_ni = 1'b0; wr_valid_i = 1'b0; cmd_valid_i = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_beats.delete(); exp_rd.delete(); exp_cmd.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        return;
      end
      if (done_cnt != d0) break;
      @(posedge clk);
      #1 budget++;
    end
    if (done_cnt == d0) flag("done_timeout", budget);
    wr_valid_i  = 1'b0;
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    logic dir;
    logic [2:0] rg;
    logic [1:0] kick;
    logic [31:0] off;
    int unsigned len;
    longint unsigned sz;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk);
    rst_ni = 1'b1;

    // WMEM write of four bytes, no kick
    for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'hA1 + i);
    run_cmd(1'b0, 3'd1, 32'h10, 4, 2'd0, 0, -1, 0);
    check("t1_beats", 64'(cmd_beats), 4);
    check("t1_first_addr", first_addr, 32'h1001_0010);
    check("t1_first_data", first_data, 8'hA1);
    check("t1_last_addr", last_addr, 32'h1001_0013);
    check("t1_last_data", last_data, 8'hA4);
    check("t1_err", last_err, 1'b0);

    // IMEM write with one stream gap, then kick to op register 0
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    run_cmd(1'b0, 3'd0, 32'h0, 2, 2'd1, 0, 1, 0);
    check("t2_beats", 64'(cmd_beats), 3);
    check("t2_gap_cycles", 64'(beat_cyc[1] - beat_cyc[0]), 2);
    check("t2_kick_addr", last_addr, 32'h1005_0000);
    check("t2_kick_data", last_data, 8'h01);

    // OMEM read-back with a toggling consumer
    rd_toggle = 1'b1;
    run_cmd(1'b1, 3'd3, 32'h20, 5, 2'd0, 0, -1, 0);
    rd_toggle = 1'b0;
    check("t3_rd_count", 64'(rd_log.size()), 5);
    check("t3_rd_first", rd_log[0], 8'h20);
    check("t3_rd_last", rd_log[4], 8'h24);

    // Rejections: overrun by one byte, illegal region, address wrap, illegal kick
    run_cmd(1'b0, 3'd2, 32'h3FF, 2, 2'd0, 0, -1, 0);
    check("t4_overrun_beats", 64'(cmd_beats), 0);
    check("t4_overrun_err", last_err, 1'b1);
    run_cmd(1'b1, 3'd6, 32'h0, 3, 2'd0, 0, -1, 0);
    check("t4_region_beats", 64'(cmd_beats), 0);
    check("t4_region_err", last_err, 1'b1);
    run_cmd(1'b0, 3'd0, 32'hFFFF_FFFF, 2, 2'd0, 0, -1, 0);
    check("t4_wrap_err", last_err, 1'b1);
    run_cmd(1'b0, 3'd0, 32'h0, 1, 2'd3, 0, -1, 0);
    check("t4_kick_err", last_err, 1'b1);
    wbuf[0] = 8'h5C; wbuf[1] = 8'hC5;
    run_cmd(1'b0, 3'd2, 32'h3FE, 2, 2'd0, 0, -1, 0);
    check("t4_edge_ok_err", last_err, 1'b0);
    check("t4_edge_ok_last", last_addr, 32'h1002_03FF);

    // Zero-length command with kick to op register 1
    run_cmd(1'b0, 3'd4, 32'h0, 0, 2'd2, 0, -1, 0);
    check("t5_beats", 64'(cmd_beats), 1);
    check("t5_kick_addr", last_addr, 32'h1005_0004);
    check("t5_err", last_err, 1'b0);

    // Reset during the third beat of an eight-beat write, then a clean command
    for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
    run_cmd(1'b0, 3'd1, 32'h40, 8, 2'd1, 0, -1, 3);
    for (int i = 0; i < 3; i++) wbuf[i] = 8'(8'h70 + i);
    run_cmd(1'b0, 3'd4, 32'h0, 3, 2'd0, 0, -1, 0);
    check("t6_beats", 64'(cmd_beats), 3);
    check("t6_first_addr", first_addr, 32'h1004_0000);
    check("t6_err", last_err, 1'b0);

    for (int n = 0; n < 40; n++) begin
      dir  = 1'($urandom);
      rg   = ($urandom % 8 == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5);
      kick = ($urandom % 12 == 0) ? 2'd3 : 2'($urandom % 3);
      len  = $urandom % 10;
      sz   = rsize(rg);
      if ($urandom % 4 == 0 && sz > 0) off = 32'(sz) - 32'($urandom % 12);
      else off = $urandom % 64;
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      run_cmd(dir, rg, off, len, kick, 30, -1, 0);
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/npu_mmap_master.md
Name: npu_mmap_master

Overview:
Host-side bus initiator that drives the NPU memory-mapped slave interface (chip enable, write enable, address, byte data). It takes region-relative transfer commands and either streams write data into IMEM/WMEM/BMEM/OMEM/PARA, or reads a region back into an output stream. It optionally finishes with a write to one of the NPU_OP_Start operation-trigger registers. It sits between the host/testbench command source and the NPU controller's address decoder.

Parameters:
DWidth, 8, bus data width in bits
ADDR_WIDTH, 32, bus address width
LEN_WIDTH, 16, transfer length counter width (in beats)

Ports:
clk  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted (high only in IDLE)
cmd_dir_i  in  1  0 = write to NPU, 1 = read from NPU
cmd_region_i  in  3  0 IMEM, 1 WMEM, 2 BMEM, 3 OMEM, 4 PARA; 5-7 illegal
cmd_offset_i  in  ADDR_WIDTH  byte offset within region
cmd_len_i  in  LEN_WIDTH  number of beats (0 allowed)
cmd_kick_i  in  2  0 none, 1 write NPU_OP_Start, 2 write NPU_OP_Start+4, 3 illegal
wr_valid_i  in  1  write-data stream valid
wr_ready_o  out  1  write-data stream ready
wr_data_i  in  DWidth  write-data byte
rd_valid_o  out  1  read-data stream valid
rd_ready_i  in  1  read-data stream ready
rd_data_o  out  DWidth  read-data byte
cen_o  out  1  bus chip enable, active-low
wen_o  out  1  bus write enable, active-low (0 = write)
addr_o  out  ADDR_WIDTH  bus address
wdata_o  out  DWidth  bus write data
rdata_i  in  DWidth  bus read data, valid exactly 1 cycle after a read beat
busy_o  out  1  high whenever state is not IDLE
done_o  out  1  one-cycle pulse at command completion
err_o  out  1  one-cycle pulse with done_o when command was rejected

Behaviour:
- Reset (async, rst_ni=0): state IDLE, cen_o=1, wen_o=1, addr_o=0, wdata_o=0, all valid/ready/busy/done/err outputs 0. Counters cleared and read buffer emptied. Reset mid-transfer abandons the transfer silently.
- The bus slave accepts one beat per cycle with no backpressure. A beat is any cycle with cen_o=0. All bus outputs are registered.
- States: IDLE, CHECK, WRITE, READ, DRAIN, KICK, DONE.
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch the command and go to CHECK.
- CHECK (1 cycle):
  - base = region Start constant from pkg_memorymap; size = End - Start.
  - Illegal region, illegal kick, or (offset + len) > size → DONE with err. The sum is computed in ADDR_WIDTH+1 bits so wrap-around is detected, not aliased. No bus activity occurs.
  - len = 0 → KICK.
  - Otherwise → WRITE or READ according to cmd_dir_i.
- WRITE:
  - wr_ready_o=1.
  - Each wr_valid_i&&wr_ready_o handshake produces a bus beat on the next cycle: cen_o=0, wen_o=0, addr_o=base+offset+idx, wdata_o=byte. idx increments per beat.
  - Idle cycles on the stream produce cen_o=1.
  - After beat len-1 → KICK.
- READ:
  - Issue a beat (cen_o=0, wen_o=1, addr incrementing) only when read-buffer occupancy plus in-flight reads < 2.
  - rdata_i is captured into the buffer one cycle after each beat.
  - After the last issue → DRAIN.
- DRAIN: wait until in-flight = 0 and the buffer is empty → KICK.
- KICK: if kick≠0, issue one write beat to NPU_OP_Start (kick=1) or NPU_OP_Start+4 (kick=2) with wdata_o=1. Then → DONE.
- DONE: done_o=1 (err_o=1 if rejected) for one cycle, then → IDLE. cmd_ready_o stays 0 until IDLE.
- The read stream obeys valid/ready: rd_data_o is held stable while rd_valid_o=1 and rd_ready_i=0. There are no drops and no duplicates.
- cmd_valid_i outside IDLE is ignored (not latched).

Decomposition:
- pkg_memorymap (existing) supplies the region Start/End and NPU_OP_Start constants.
- Add to pkg_memorymap:
  - a region enum npu_region_e (IMEM, WMEM, BMEM, OMEM, PARA);
  - a kick enum npu_kick_e;
  - a master FSM state typedef.
- Sub-module npu_rd_skid: 2-entry FIFO for read data, exposing push, a valid/ready pop, and a count output.

Test Plan:
- Write WMEM, offset 0x10, len 4, data 0xA1..0xA4, kick 0 → four beats at WMEM_Start+0x10..0x13, wen_o=0, correct bytes; done_o 1 cycle after the last beat plus KICK; err_o=0.
- Write IMEM, len 2, kick 1 with a wr_valid_i gap cycle → cen_o=1 during the gap; final beat addr=NPU_OP_Start, wdata_o=0x01.
- Read OMEM, len 5, rdata_i=addr[7:0], rd_ready_i toggling 1/0 → rd_data_o sequence matches the five addresses in order, never more than 2 reads outstanding plus buffered.
- Command with offset = size-1 and len 2, and separately region 6 → no cen_o=0 beats; done_o and err_o pulse together.
- len 0 with kick 2 → a single write beat to NPU_OP_Start+4, then done_o.
- Deassert rst_ni during beat 3 of an 8-beat write → outputs return to reset values immediately; the next command runs normally.
